// File: rtl/emit_scheduler.sv
`default_nettype none
// ============================================================================
// emit_scheduler : plays one output-buffer window to the left/right CODEC sinks
// Revision 1.0 - initial release
// ============================================================================
module emit_scheduler #(
  parameter int WINDOW_LEN = 512,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2 + $clog2(WINDOW_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_in,
  input  logic [1:0]        window_start,
  output logic              go_out,
  output logic              busy,
  output logic              overrun,
  output logic              buf_rden,
  output logic [ADDR_W-1:0] buf_rdaddr,
  input  logic [DATA_W-1:0] buf_rddata,
  output logic [DATA_W-1:0] left_out_data,
  output logic              left_out_valid,
  input  logic              left_out_ready,
  output logic [DATA_W-1:0] right_out_data,
  output logic              right_out_valid,
  input  logic              right_out_ready
);

  localparam int IDX_W = $clog2(WINDOW_LEN);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WINDOW_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic [1:0]       r_window;
  logic [IDX_W-1:0] r_idx;

  logic             w_left_acc;
  logic             w_right_acc;
  logic             w_both_done;
  logic [IDX_W-1:0] w_idx_next;

  // A channel counts as finished once its valid is already low or it is
  // accepting on this edge; the sample retires when both are finished.
  assign w_left_acc  = left_out_valid & left_out_ready;
  assign w_right_acc = right_out_valid & right_out_ready;
  assign w_both_done = (~left_out_valid | left_out_ready) &
                       (~right_out_valid | right_out_ready);
  assign w_idx_next  = r_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_window        <= 2'd0;
      r_idx           <= '0;
      go_out          <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      buf_rden        <= 1'b0;
      buf_rdaddr      <= '0;
      left_out_data   <= '0;
      left_out_valid  <= 1'b0;
      right_out_data  <= '0;
      right_out_valid <= 1'b0;
    end else begin
      go_out  <= 1'b0;
      overrun <= go_in && (r_state != ST_IDLE);

      case (r_state)
        ST_IDLE: begin
          if (go_in) begin
            r_window   <= window_start;
            r_idx      <= '0;
            buf_rden   <= 1'b1;
            buf_rdaddr <= ADDR_W'({window_start, {IDX_W{1'b0}}});
            busy       <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          buf_rden <= 1'b0;
          r_state  <= ST_WAIT;
        end

        // RAM output is valid in this cycle; capture it for both sinks.
        ST_WAIT: begin
          left_out_data   <= buf_rddata;
          right_out_data  <= buf_rddata;
          left_out_valid  <= 1'b1;
          right_out_valid <= 1'b1;
          r_state         <= ST_PRESENT;
        end

        ST_PRESENT: begin
          if (w_left_acc)  left_out_valid  <= 1'b0;
          if (w_right_acc) right_out_valid <= 1'b0;
          if (w_both_done) begin
            if (r_idx == c_last_idx) begin
              go_out  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx      <= w_idx_next;
              buf_rden   <= 1'b1;
              buf_rdaddr <= ADDR_W'({r_window, w_idx_next});
              r_state    <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          busy            <= 1'b0;
          buf_rden        <= 1'b0;
          left_out_valid  <= 1'b0;
          right_out_valid <= 1'b0;
          r_state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_emit_scheduler.sv
`default_nettype none
// Bench for emit_scheduler with a 4-sample window; expected traffic is derived
// from the window index and RAM contents, not from the scheduler's internals.
module tb_emit_scheduler;

  localparam int WL = 4;
  localparam int DW = 16;
  localparam int AW = 2 + $clog2(WL);

  logic          clk = 1'b0;
  logic          reset;
  logic          go_in;
  logic [1:0]    window_start;
  logic          go_out;
  logic          busy;
  logic          overrun;
  logic          buf_rden;
  logic [AW-1:0] buf_rdaddr;
  logic [DW-1:0] buf_rddata = '0;
  logic [DW-1:0] left_out_data;
  logic          left_out_valid;
  logic          left_out_ready;
  logic [DW-1:0] right_out_data;
  logic          right_out_valid;
  logic          right_out_ready;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:4*WL-1];
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_left [$];
  logic [DW-1:0] q_right [$];
  int            go_cnt = 0;
  int            ov_cnt = 0;
  logic          pl_v = 1'b0, pr_v = 1'b0;
  logic [DW-1:0] pl_d = '0, pr_d = '0;

  emit_scheduler #(.WINDOW_LEN(WL), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .go_in           (go_in),
    .window_start    (window_start),
    .go_out          (go_out),
    .busy            (busy),
    .overrun         (overrun),
    .buf_rden        (buf_rden),
    .buf_rdaddr      (buf_rdaddr),
    .buf_rddata      (buf_rddata),
    .left_out_data   (left_out_data),
    .left_out_valid  (left_out_valid),
    .left_out_ready  (left_out_ready),
    .right_out_data  (right_out_data),
    .right_out_valid (right_out_valid),
    .right_out_ready (right_out_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the read enable.
  always @(posedge clk) if (buf_rden) buf_rddata <= mem[buf_rdaddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: records reads and accepted samples, and checks the sink handshake rules.
  always @(negedge clk) begin
    if (reset) begin
      pl_v = 1'b0;
      pr_v = 1'b0;
    end else begin
      if (buf_rden) begin
        q_addr.push_back(buf_rdaddr);
        check("no_fetch_while_valid", 32'({left_out_valid, right_out_valid}), 32'd0);
      end
      if (pl_v) begin
        check("left_hold_valid", 32'(left_out_valid), 32'd1);
        check("left_hold_data", 32'(left_out_data), 32'(pl_d));
      end
      if (pr_v) begin
        check("right_hold_valid", 32'(right_out_valid), 32'd1);
        check("right_hold_data", 32'(right_out_data), 32'(pr_d));
      end
      if (left_out_valid && left_out_ready)   q_left.push_back(left_out_data);
      if (right_out_valid && right_out_ready) q_right.push_back(right_out_data);
      pl_v = left_out_valid && !left_out_ready;
      pl_d = left_out_data;
      pr_v = right_out_valid && !right_out_ready;
      pr_d = right_out_data;
      if (go_out)  go_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic go(input logic [1:0] w, input logic [1:0] w_after);
    q_addr.delete();
    q_left.delete();
    q_right.delete();
    go_cnt = 0;
    ov_cnt = 0;
    @(posedge clk); #1;
    go_in = 1'b1;
    window_start = w;
    @(posedge clk); #1;
    go_in = 1'b0;
    window_start = w_after;
  endtask

  // mode 0: both ready; 1: independent random; 2: shared random bit
  task automatic run_done(input int mode);
    int  n;
    logic b;
    n = 0;
    while (go_cnt == 0 && n < 400) begin
      @(posedge clk); #1;
      b = 1'($urandom_range(0, 1));
      case (mode)
        0:       begin left_out_ready = 1'b1; right_out_ready = 1'b1; end
        1:       begin left_out_ready = 1'($urandom_range(0, 1)); right_out_ready = 1'($urandom_range(0, 1)); end
        default: begin left_out_ready = b; right_out_ready = b; end
      endcase
      n++;
    end
    @(posedge clk); #1;
    check("go_out_seen", 32'(go_cnt), 32'd1);
  endtask

  task automatic check_window(input logic [1:0] w, input int exp_ov);
    int base;
    base = int'(w) * WL;
    check("go_out_count", 32'(go_cnt), 32'd1);
    check("overrun_count", 32'(ov_cnt), 32'(exp_ov));
    check("addr_count", 32'(q_addr.size()), 32'(WL));
    check("left_count", 32'(q_left.size()), 32'(WL));
    check("right_count", 32'(q_right.size()), 32'(WL));
    for (int i = 0; i < WL; i++) begin
      if (i < q_addr.size())  check("addr_seq", 32'(q_addr[i]), 32'(base + i));
      if (i < q_left.size())  check("left_data", 32'(q_left[i]), 32'(mem[base + i]));
      if (i < q_right.size()) check("right_data", 32'(q_right[i]), 32'(mem[base + i]));
    end
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] w;
    reset = 1'b1;
    go_in = 1'b0;
    window_start = 2'd0;
    left_out_ready = 1'b0;
    right_out_ready = 1'b0;
    for (int i = 0; i < 4 * WL; i++) mem[i] = DW'(16'h1000 + i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({go_out, busy, overrun, buf_rden, buf_rdaddr, left_out_valid, right_out_valid}), 32'd0);
    check("reset_data", 32'({left_out_data, right_out_data}), 32'd0);
    reset = 1'b0;

    // Nominal playback of window 2 with both sinks always ready.
    left_out_ready = 1'b1;
    right_out_ready = 1'b1;
    go(2'd2, 2'd2);
    check("lat_rden", 32'(buf_rden), 32'd1);
    check("lat_addr", 32'(buf_rdaddr), 32'd8);
    check("lat_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_wait_rden", 32'(buf_rden), 32'd0);
    @(posedge clk); #1;
    check("lat_valids", 32'({left_out_valid, right_out_valid}), 32'h3);
    check("lat_data", 32'(left_out_data), 32'h1008);
    n = 0;
    while (!go_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_pulse", 32'(go_out), 32'd1);
    check("done_all_accepted", 32'(q_left.size()), 32'(WL));
    check("done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_single", 32'(go_out), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check_window(2'd2, 0);

    // Left sink stalls on sample 0 while right accepts.
    left_out_ready = 1'b0;
    right_out_ready = 1'b1;
    go(2'd2, 2'd2);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("stall_fetches", 32'(q_addr.size()), 32'd1);
    check("stall_right_acc", 32'(q_right.size()), 32'd1);
    check("stall_left_acc", 32'(q_left.size()), 32'd0);
    check("stall_valids", 32'({left_out_valid, right_out_valid}), 32'h2);
    check("stall_left_data", 32'(left_out_data), 32'h1008);
    run_done(0);
    check_window(2'd2, 0);

    // Both readies toggle together.
    go(2'd2, 2'd2);
    run_done(2);
    check_window(2'd2, 0);

    // go_in during PRESENT and during DONE.
    left_out_ready = 1'b1;
    right_out_ready = 1'b1;
    go(2'd1, 2'd1);
    begin
      logic inj_p, inj_d;
      inj_p = 1'b0;
      inj_d = 1'b0;
      for (int c = 0; c < 200 && go_cnt == 0; c++) begin
        @(posedge clk); #1;
        go_in = 1'b0;
        if (!inj_p && left_out_valid) begin go_in = 1'b1; inj_p = 1'b1; end
        if (!inj_d && go_out)         begin go_in = 1'b1; inj_d = 1'b1; end
      end
      @(posedge clk); #1;
      go_in = 1'b0;
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_window(2'd1, 2);

    // window_start changes after the go is accepted.
    go(2'd0, 2'd3);
    run_done(1);
    check_window(2'd0, 0);

    // Reset in the middle of PRESENT, then a clean restart on window 1.
    left_out_ready = 1'b0;
    right_out_ready = 1'b0;
    go(2'd0, 2'd0);
    n = 0;
    while (!left_out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_present_reached", 32'(left_out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_ctrl", 32'({go_out, busy, overrun, buf_rden, buf_rdaddr, left_out_valid, right_out_valid}), 32'd0);
    check("midreset_data", 32'({left_out_data, right_out_data}), 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midreset_no_go_out", 32'(go_cnt), 32'd0);
    check("midreset_idle", 32'(busy), 32'd0);
    go(2'd1, 2'd1);
    run_done(1);
    check_window(2'd1, 0);

    // Random RAM contents, windows and backpressure.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4 * WL; i++) mem[i] = DW'($urandom);
      w = 2'($urandom_range(0, 3));
      go(w, 2'($urandom));
      run_done(1);
      check_window(w, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/emit_scheduler.md
Name: emit_scheduler

Overview:
Sequences playback of one completed output window from the shared 4-window output sample buffer to the Wolfson CODEC left/right to_dac Avalon-ST sinks. Started by the stitcher with a go pulse and a window index, it reads the window sample by sample and presents each sample to both channels. It pulses go_out back to the stitcher when the whole window has been accepted. It sits between the stitcher, the output buffer RAM read port and the audio CODEC.

Parameters:
WINDOW_LEN, 512, samples per window; power of two, >= 2
DATA_W, 16, sample width
ADDR_W, 2 + clog2(WINDOW_LEN), output buffer read address width (derived)

Ports:
clk  in  1  system clock; one clock domain
reset  in  1  synchronous, active-high reset
go_in  in  1  stitcher start pulse; sampled only in IDLE
window_start  in  2  window index, latched when go_in is accepted
go_out  out  1  one-cycle pulse when the window is fully emitted
busy  out  1  high in every state except IDLE
overrun  out  1  one-cycle pulse when go_in arrives outside IDLE
buf_rden  out  1  output buffer read enable
buf_rdaddr  out  ADDR_W  read address = {window, idx}
buf_rddata  in  DATA_W  RAM data, valid 1 cycle after buf_rden
left_out_data  out  DATA_W  sample to left sink
left_out_valid  out  1  Avalon-ST valid, left
left_out_ready  in  1  Avalon-ST ready, left
right_out_data  out  DATA_W  sample to right sink
right_out_valid  out  1  Avalon-ST valid, right
right_out_ready  in  1  Avalon-ST ready, right

Behaviour:
- Reset: state IDLE, idx=0, window reg=0. All outputs 0: go_out, busy, overrun, buf_rden, buf_rdaddr, both data buses and both valids. Reset overrides all other activity, including mid-window; no go_out is pulsed.
- IDLE: if go_in, latch window_start and clear idx, then go to FETCH. Later changes to window_start are ignored until the next accepted go_in.
- FETCH, one cycle: buf_rden=1, buf_rdaddr={window, idx}, then go to WAIT.
- WAIT, one cycle: buf_rden=0. At the end of this cycle, load buf_rddata into both left_out_data and right_out_data, set both valids, then go to PRESENT.
- PRESENT: each channel is handled independently. A channel's valid clears at the clock edge where valid && ready for that channel. Its data holds stable while its valid is high.
- Leaving PRESENT: once both channels have accepted, including when both accept in the same cycle, move on at that same edge. If idx == WINDOW_LEN-1, go to DONE. Otherwise idx+1 and go to FETCH.
- An early-accepting channel stays low. It is not reasserted until the next sample.
- DONE, one cycle: go_out=1, then go to IDLE. The next go_in is accepted from the following cycle.
- Latency: go_in sampled at edge t gives buf_rden high in cycle t+1 and both valids high from cycle t+3. With ready always high, one sample is emitted per 3 cycles.
- overrun: pulses for one cycle, registered, for every cycle go_in is high while state != IDLE (this includes DONE). The window in progress is unaffected.
- The data regs keep their last value after acceptance; only valid matters.
- idx is clog2(WINDOW_LEN) bits and never wraps within a window. Every address of the selected window is read exactly once, in ascending order.

Test Plan:
1. WINDOW_LEN=4, RAM[i]=0x1000+i, both readys held 1, go_in with window_start=2 -> rdaddr 8,9,10,11 in order; both channels carry 0x1008..0x100B, each accepted once; go_out pulses 1 cycle after the last accept; busy drops the next cycle.
2. right_ready=1, left_ready=0 for 10 cycles on sample 0 -> right accepts and right_valid=0; left_valid stays 1 with data 0x1008 stable; no FETCH of address 9 until left_ready=1.
3. Both readys rise in the same cycle on every sample -> single-cycle accept, no duplicated or dropped sample, 4 samples total.
4. go_in pulsed during PRESENT and during DONE -> overrun pulses on each; playback continues; exactly one go_out; idle afterwards.
5. window_start changed 0 to 3 mid-run -> addresses stay in the originally latched window.
6. reset asserted mid-PRESENT -> next cycle all outputs 0, state IDLE, no go_out. A new go_in with window_start=1 then plays addresses 4..7 correctly.
